// File: rtl/cb_shift_pkg.sv
// Shared types for the CB-prefix shift/rotate engine: op and state encodings,
// Z80 flag bit positions, and the flag generator also used by the tv80 benches.
package cb_shift_pkg;

  localparam int MAX_DW = 64;

  typedef enum logic [2:0] {
    OP_RLC = 3'd0,
    OP_RRC = 3'd1,
    OP_RL  = 3'd2,
    OP_RR  = 3'd3,
    OP_SLA = 3'd4,
    OP_SRA = 3'd5,
    OP_SLL = 3'd6,
    OP_SRL = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WR    = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int FLAG_S = 7;
  localparam int FLAG_Z = 6;
  localparam int FLAG_Y = 5;
  localparam int FLAG_H = 4;
  localparam int FLAG_X = 3;
  localparam int FLAG_P = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 0;

  // res must be zero-extended from the operand width; sign is the operand MSB.
  function automatic logic [7:0] cb_flags(input logic [MAX_DW-1:0] res,
                                          input logic sign,
                                          input logic c);
    logic [7:0] f;
    f         = 8'h00;
    f[FLAG_S] = sign;
    f[FLAG_Z] = (res == '0);
    f[FLAG_Y] = res[5];
    f[FLAG_H] = 1'b0;
    f[FLAG_X] = res[3];
    f[FLAG_P] = ~^res;
    f[FLAG_N] = 1'b0;
    f[FLAG_C] = c;
    return f;
  endfunction

endpackage

// File: rtl/cb_shift_step.sv
// One combinational shift/rotate step of the CB group; zero latency, no flow control.
module cb_shift_step #(
  parameter int DW = 8
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] x,
  input  logic          c,
  output logic [DW-1:0] x_nxt,
  output logic          c_nxt
);
  import cb_shift_pkg::*;

  always_comb begin
    x_nxt = x;
    c_nxt = c;
    case (op)
      OP_RLC: begin x_nxt = {x[DW-2:0], x[DW-1]}; c_nxt = x[DW-1]; end
      OP_RRC: begin x_nxt = {x[0], x[DW-1:1]};    c_nxt = x[0];    end
      OP_RL:  begin x_nxt = {x[DW-2:0], c};       c_nxt = x[DW-1]; end
      OP_RR:  begin x_nxt = {c, x[DW-1:1]};       c_nxt = x[0];    end
      OP_SLA: begin x_nxt = {x[DW-2:0], 1'b0};    c_nxt = x[DW-1]; end
      OP_SRA: begin x_nxt = {x[DW-1], x[DW-1:1]}; c_nxt = x[0];    end
      OP_SLL: begin x_nxt = {x[DW-2:0], 1'b1};    c_nxt = x[DW-1]; end
      OP_SRL: begin x_nxt = {1'b0, x[DW-1:1]};    c_nxt = x[0];    end
      default: begin x_nxt = x; c_nxt = c; end
    endcase
  end

endmodule

// File: rtl/cb_shift_engine.sv
// Sequential CB shift/rotate executor with optional memory read-modify-write.
// Latency n+1 (register) or n+3 (memory, zero-wait); bus phases stall until mem_ack.
module cb_shift_engine #(
  parameter int DW    = 8,
  parameter int AW    = 16,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             mem_mode,
  input  logic [AW-1:0]    addr,
  input  logic [DW-1:0]    reg_in,
  input  logic [7:0]       flags_in,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [DW-1:0]    result,
  output logic [7:0]       flags_out,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  input  logic             mem_ack
);
  import cb_shift_pkg::*;

  state_e           state;
  logic [2:0]       op_q;
  logic             mem_mode_q;
  logic [CNT_W-1:0] rem;
  logic [DW-1:0]    work;
  logic             carry;

  logic [DW-1:0]     x_nxt;
  logic              c_nxt;
  logic [DW-1:0]     fin_x;
  logic              fin_c;
  logic [MAX_DW-1:0] fin_ext;
  logic [7:0]        fin_flags;
  logic              unused_flags;

  assign unused_flags = ^flags_in[7:1];

  cb_shift_step #(.DW(DW)) u_step (
    .op    (op_q),
    .x     (work),
    .c     (carry),
    .x_nxt (x_nxt),
    .c_nxt (c_nxt)
  );

  // Final value comes straight from the step in register mode, from the
  // already-shifted working register when finishing a memory write.
  always_comb begin
    fin_x   = (state == ST_SHIFT) ? x_nxt : work;
    fin_c   = (state == ST_SHIFT) ? c_nxt : carry;
    fin_ext = '0;
    fin_ext[DW-1:0] = fin_x;
  end

  assign fin_flags = cb_flags(fin_ext, fin_x[DW-1], fin_c);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_q       <= 3'd0;
      mem_mode_q <= 1'b0;
      rem        <= '0;
      work       <= '0;
      carry      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      flags_out  <= 8'h00;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q       <= op;
            mem_mode_q <= mem_mode;
            carry      <= flags_in[0];
            rem        <= (count == '0) ? CNT_W'(1) : count;
            busy       <= 1'b1;
            if (mem_mode) begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= addr;
              state    <= ST_RD;
            end else begin
              work  <= reg_in;
              state <= ST_SHIFT;
            end
          end
        end
        ST_RD: begin
          if (mem_ack) begin
            work    <= mem_rdata;
            mem_req <= 1'b0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          work  <= x_nxt;
          carry <= c_nxt;
          rem   <= rem - CNT_W'(1);
          if (rem == CNT_W'(1)) begin
            if (mem_mode_q) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_wdata <= x_nxt;
              state     <= ST_WR;
            end else begin
              done      <= 1'b1;
              result    <= fin_x;
              flags_out <= fin_flags;
              state     <= ST_DONE;
            end
          end
        end
        ST_WR: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            done      <= 1'b1;
            result    <= fin_x;
            flags_out <= fin_flags;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cb_shift_engine.sv
// Bench for cb_shift_engine: 8-bit instance with a memory responder, 16-bit register-only instance.
module tb_cb_shift_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic        mem_mode;
  logic [15:0] addr;
  logic [7:0]  reg_in;
  logic [7:0]  flags_in;
  logic [2:0]  count;
  logic        busy, done;
  logic [7:0]  result, flags_out;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  logic        w_start;
  logic [2:0]  w_op;
  logic        w_mem_mode = 1'b0;
  logic [15:0] w_addr = 16'h0000;
  logic [15:0] w_reg_in;
  logic [7:0]  w_flags_in;
  logic [2:0]  w_count;
  logic        w_busy, w_done;
  logic [15:0] w_result;
  logic [7:0]  w_flags_out;
  logic        w_mem_req, w_mem_we;
  logic [15:0] w_mem_addr;
  logic [15:0] w_mem_wdata;
  logic [15:0] w_mem_rdata = 16'h0000;
  logic        w_mem_ack = 1'b0;

  logic [7:0] mem [0:65535];
  int  wait_cfg, wait_left;
  bit  hold_ack;
  int  rd_cnt, wr_cnt;
  int  vectors, miscompares;

  always #5 clk = ~clk;

  cb_shift_engine #(.DW(8), .AW(16), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .mem_mode(mem_mode),
    .addr(addr), .reg_in(reg_in), .flags_in(flags_in), .count(count),
    .busy(busy), .done(done), .result(result), .flags_out(flags_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  cb_shift_engine #(.DW(16), .AW(16), .CNT_W(3)) dut_w (
    .clk(clk), .reset(reset), .start(w_start), .op(w_op), .mem_mode(w_mem_mode),
    .addr(w_addr), .reg_in(w_reg_in), .flags_in(w_flags_in), .count(w_count),
    .busy(w_busy), .done(w_done), .result(w_result), .flags_out(w_flags_out),
    .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata),
    .mem_rdata(w_mem_rdata), .mem_ack(w_mem_ack)
  );

  // Memory responder: wait_cfg wait cycles per bus phase, then a same-cycle ack.
  always @(negedge clk) begin
    if (mem_req && !hold_ack) begin
      if (wait_left > 0) begin
        wait_left = wait_left - 1;
        mem_ack   = 1'b0;
      end else begin
        mem_ack   = 1'b1;
        wait_left = wait_cfg;
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          wr_cnt = wr_cnt + 1;
        end else begin
          mem_rdata = mem[mem_addr];
          rd_cnt = rd_cnt + 1;
        end
      end
    end else begin
      mem_ack   = 1'b0;
      wait_left = wait_cfg;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors = vectors + 1;
    if (got !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: apply the op n times on a w-bit value using integer arithmetic.
  function automatic logic [16:0] ref_op(input int op_i, input int w, input logic [15:0] x0,
                                         input logic c0, input int n);
    int unsigned x, c, msb, lsb, mask;
    mask = (32'd1 << w) - 1;
    x = x0 & mask;
    c = c0;
    for (int i = 0; i < n; i++) begin
      msb = (x >> (w - 1)) & 1;
      lsb = x & 1;
      case (op_i)
        0: begin x = ((x << 1) | msb) & mask;       c = msb; end
        1: begin x = (x >> 1) | (lsb << (w - 1));   c = lsb; end
        2: begin x = ((x << 1) | c) & mask;         c = msb; end
        3: begin x = (x >> 1) | (c << (w - 1));     c = lsb; end
        4: begin x = (x << 1) & mask;               c = msb; end
        5: begin x = (x >> 1) | (msb << (w - 1));   c = lsb; end
        6: begin x = ((x << 1) | 1) & mask;         c = msb; end
        default: begin x = x >> 1;                  c = lsb; end
      endcase
    end
    return {c[0], x[15:0]};
  endfunction

  function automatic logic [7:0] ref_flags(input int w, input logic [15:0] r, input logic c);
    logic [7:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < w; i++) ones += int'((r >> i) & 16'd1);
    f = 8'h00;
    if (((r >> (w - 1)) & 16'd1) != 0) f = f | 8'h80;
    if (r == 16'h0000)                 f = f | 8'h40;
    if (r[5])                          f = f | 8'h20;
    if (r[3])                          f = f | 8'h08;
    if (ones % 2 == 0)                 f = f | 8'h04;
    if (c)                             f = f | 8'h01;
    return f;
  endfunction

  task automatic run8(input string tag, input int op_i, input bit mm, input logic [7:0] rv,
                      input logic [7:0] fi, input int cnt, input logic [15:0] ad,
                      input int ws, input bit inject);
    logic [16:0] m;
    logic [7:0]  x0;
    int n, exp_lat, lat, r0, w0;
    bit seen;
    n = (cnt == 0) ? 1 : cnt;
    x0 = mm ? mem[ad] : rv;
    m = ref_op(op_i, 8, {8'h00, x0}, fi[0], n);
    exp_lat = mm ? n + 3 + 2 * ws : n + 1;
    r0 = rd_cnt;
    w0 = wr_cnt;
    wait_cfg = ws;
    @(negedge clk);
    start = 1'b1; op = 3'(op_i); mem_mode = mm; reg_in = rv;
    flags_in = fi; count = 3'(cnt); addr = ad;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'($urandom); mem_mode = 1'($urandom); reg_in = 8'($urandom);
    flags_in = 8'($urandom); count = 3'($urandom); addr = 16'($urandom);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check_val({tag, "_busy"}, 32'(busy), 32'd1);
      if (inject && lat == 2) start = 1'b1;
      if (inject && lat == 3) start = 1'b0;
      if (done) seen = 1'b1;
    end
    check_val({tag, "_done_seen"}, 32'(seen), 32'd1);
    check_val({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_val({tag, "_result"}, 32'(result), 32'(m[7:0]));
    check_val({tag, "_flags"}, 32'(flags_out), 32'(ref_flags(8, {8'h00, m[7:0]}, m[16])));
    check_val({tag, "_req_at_done"}, 32'(mem_req), 32'd0);
    check_val({tag, "_reads"}, 32'(rd_cnt - r0), mm ? 32'd1 : 32'd0);
    check_val({tag, "_writes"}, 32'(wr_cnt - w0), mm ? 32'd1 : 32'd0);
    if (mm) check_val({tag, "_memval"}, 32'(mem[ad]), 32'(m[7:0]));
    if (inject) begin
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_val({tag, "_idle_after"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic run16(input string tag, input int op_i, input logic [15:0] rv,
                       input logic [7:0] fi, input int cnt);
    logic [16:0] m;
    int lat;
    bit seen;
    m = ref_op(op_i, 16, rv, fi[0], (cnt == 0) ? 1 : cnt);
    @(negedge clk);
    w_start = 1'b1; w_op = 3'(op_i); w_reg_in = rv; w_flags_in = fi; w_count = 3'(cnt);
    @(posedge clk);
    #1;
    w_start = 1'b0; w_reg_in = 16'($urandom);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 50) begin
      @(negedge clk);
      lat++;
      if (w_done) seen = 1'b1;
    end
    check_val({tag, "_done_seen"}, 32'(seen), 32'd1);
    check_val({tag, "_result"}, 32'(w_result), 32'(m[15:0]));
    check_val({tag, "_flags"}, 32'(w_flags_out), 32'(ref_flags(16, m[15:0], m[16])));
  endtask

  initial begin
    int w0;
    vectors = 0; miscompares = 0; rd_cnt = 0; wr_cnt = 0;
    wait_cfg = 0; wait_left = 0; hold_ack = 1'b0;
    mem_ack = 1'b0; mem_rdata = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    reset = 1'b1; start = 1'b0; op = 3'd0; mem_mode = 1'b0; addr = 16'h0000;
    reg_in = 8'h00; flags_in = 8'h00; count = 3'd1;
    w_start = 1'b0; w_op = 3'd0; w_reg_in = 16'h0000; w_flags_in = 8'h00; w_count = 3'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_req", 32'(mem_req), 32'd0);
    check_val("rst_we", 32'(mem_we), 32'd0);
    check_val("rst_result", 32'(result), 32'd0);
    check_val("rst_flags", 32'(flags_out), 32'd0);
    check_val("rst_addr", 32'(mem_addr), 32'd0);
    check_val("rst_wdata", 32'(mem_wdata), 32'd0);
    check_val("rst_w_busy", 32'(w_busy), 32'd0);
    reset = 1'b0;

    run8("srl_reg", 7, 1'b0, 8'h7C, 8'h00, 1, 16'h0000, 0, 1'b0);
    check_val("srl_reg_lit_res", 32'(result), 32'h3E);
    check_val("srl_reg_lit_flg", 32'(flags_out), 32'h28);

    mem[16'h4FF2] = 8'hAA;
    run8("srl_mem", 7, 1'b1, 8'h00, 8'h00, 1, 16'h4FF2, 0, 1'b0);
    check_val("srl_mem_lit_mem", 32'(mem[16'h4FF2]), 32'h55);
    check_val("srl_mem_lit_flg", 32'(flags_out), 32'h04);

    run8("rl_reg", 2, 1'b0, 8'h80, 8'h01, 1, 16'h0000, 0, 1'b0);
    check_val("rl_reg_lit_res", 32'(result), 32'h01);
    check_val("rl_reg_lit_flg", 32'(flags_out), 32'h01);

    run8("sra_cnt3", 5, 1'b0, 8'h81, 8'h00, 3, 16'h0000, 0, 1'b0);
    check_val("sra_cnt3_lit_res", 32'(result), 32'hF0);
    check_val("sra_cnt3_lit_flg", 32'(flags_out), 32'hA4);

    // Reset while a read is stalled: bus drops at once and no write follows.
    hold_ack = 1'b1;
    w0 = wr_cnt;
    @(negedge clk);
    start = 1'b1; mem_mode = 1'b1; op = 3'd7; addr = 16'h1234; count = 3'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rd_hold_req", 32'(mem_req), 32'd1);
    check_val("rd_hold_we", 32'(mem_we), 32'd0);
    check_val("rd_hold_addr", 32'(mem_addr), 32'h1234);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_val("rd_rst_req", 32'(mem_req), 32'd0);
    check_val("rd_rst_busy", 32'(busy), 32'd0);
    check_val("rd_rst_result", 32'(result), 32'd0);
    check_val("rd_rst_flags", 32'(flags_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    hold_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rd_rst_no_write", 32'(wr_cnt - w0), 32'd0);
    check_val("rd_rst_idle_req", 32'(mem_req), 32'd0);

    run8("rlc_cnt0", 0, 1'b0, 8'h81, 8'h00, 0, 16'h0000, 0, 1'b0);
    check_val("rlc_cnt0_lit_res", 32'(result), 32'h03);
    run8("rr_ignore_start", 3, 1'b0, 8'hB5, 8'h01, 6, 16'h0000, 0, 1'b1);
    run8("sra_mem_ws", 5, 1'b1, 8'h00, 8'h01, 4, 16'h00C3, 2, 1'b0);

    run16("w_sla", 4, 16'h8000, 8'h00, 1);
    check_val("w_sla_lit_res", 32'(w_result), 32'h0000);
    check_val("w_sla_lit_flg", 32'(w_flags_out), 32'h45);
    for (int i = 0; i < 12; i++)
      run16($sformatf("w_rand%0d", i), int'($urandom_range(0, 7)), 16'($urandom),
            8'($urandom), int'($urandom_range(0, 7)));

    for (int i = 0; i < 150; i++)
      run8($sformatf("rand%0d", i), int'($urandom_range(0, 7)), 1'($urandom),
           8'($urandom), 8'($urandom), int'($urandom_range(0, 7)), 16'($urandom),
           int'($urandom_range(0, 2)), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cb_shift_engine.md
# cb_shift_engine

Parametrised, sequential executor for the CB-prefix shift/rotate group (RLC, RRC, RL, RR, SLA, SRA, SLL, SRL) with Z80-compatible flag generation.
- Generalises the single-step 8-bit register shift: configurable data width, multi-step shift count, and a read-modify-write sequencer for memory operands such as (HL).
- Sits beside the tv80 ALU as an offload unit; the core issues a request and waits for `done`.

## Interface
Parameters:
- `DW`, 8: operand width in bits (≥ 8).
- `AW`, 16: memory address width.
- `CNT_W`, 3: width of the shift-count field.

Ports:
- `clk` in 1: the single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request; sampled only in IDLE.
- `op` in 3: Z80 encoding. 0 RLC, 1 RRC, 2 RL, 3 RR, 4 SLA, 5 SRA, 6 SLL, 7 SRL.
- `mem_mode` in 1: 1 = operand at `addr`; 0 = operand on `reg_in`.
- `addr` in AW: memory operand address.
- `reg_in` in DW: register operand.
- `flags_in` in 8: incoming F; only bit 0 (C) is used.
- `count` in CNT_W: number of single-bit steps; 0 is treated as 1.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when `result`/`flags_out` become valid.
- `result` out DW: shifted value.
- `flags_out` out 8: S Z Y H X P/V N C, with S in bit 7 down to C in bit 0.
- `mem_req` out 1: bus request.
- `mem_we` out 1: write qualifier for `mem_req`.
- `mem_addr` out AW: bus address.
- `mem_wdata` out DW: write data.
- `mem_rdata` in DW: read data.
- `mem_ack` in 1: completes the current bus cycle in the same clock.

## Operation
- States: IDLE, RD, SHIFT, WR, DONE.
- IDLE + `start`:
  - Latch `op`, `addr`, the count (n = max(`count`,1)) and carry = `flags_in[0]`.
  - If `mem_mode`: go to RD.
  - Otherwise: latch `reg_in` into the working register and go to SHIFT.
- RD:
  - Drive `mem_req`=1, `mem_we`=0, `mem_addr`=latched addr.
  - On `mem_ack`: latch `mem_rdata` and go to SHIFT. Without ack, hold indefinitely.
- SHIFT: one step per cycle for n cycles, with x = working value and c = carry.
  - RLC: {x[DW-2:0],x[DW-1]}, c=x[DW-1].
  - RRC: {x[0],x[DW-1:1]}, c=x[0].
  - RL: {x[DW-2:0],c}, c=x[DW-1].
  - RR: {c,x[DW-1:1]}, c=x[0].
  - SLA: {x[DW-2:0],0}, c=x[DW-1].
  - SRA: {x[DW-1],x[DW-1:1]}, c=x[0].
  - SLL: {x[DW-2:0],1}, c=x[DW-1].
  - SRL: {0,x[DW-1:1]}, c=x[0].
  - Carry chains across steps.
  - Exit to WR if `mem_mode`, otherwise to DONE.
- WR:
  - Drive `mem_req`=1, `mem_we`=1, `mem_wdata`=result.
  - Hold until `mem_ack`, then go to DONE.
- DONE:
  - Pulse `done`, update `result`/`flags_out`, return to IDLE.
  - Outputs hold until the next DONE.
- Flags:
  - S = result[DW-1].
  - Z = (result == 0).
  - Y = result[5], X = result[3].
  - H = 0, N = 0.
  - P/V = even parity over all DW bits.
  - C = final c.
- `start` while busy is ignored; it is not queued.

## Timing
- Reset values: `busy`, `done`, `mem_req`, `mem_we` = 0; `result`, `mem_addr`, `mem_wdata` = 0; `flags_out` = 00; state IDLE.
- Register mode latency: `start` sampled at edge 0, SHIFT on edges 1..n, `done` high in cycle n+1.
- Memory mode latency (zero-wait ack): RD 1 cycle, SHIFT n, WR 1, `done` in cycle n+3. Each wait cycle on either bus phase adds 1.
- `mem_req` is never asserted in SHIFT or DONE. Exactly one read and one write occur per memory-mode operation.
- Reset in any state: IDLE on the next edge, `mem_req` dropped, any pending write abandoned, outputs return to reset values.
- Re-issue: `start` in the cycle after `done` is accepted (back-to-back operation).

## Structure
- `cb_shift_pkg` holds:
  - the op enum (RLC..SRL);
  - the state enum;
  - flag bit-position constants (FLAG_S=7 … FLAG_C=0).
- Sub-module `cb_shift_step`, combinational, one step:
  - inputs: op, x, c;
  - outputs: x', c'.
  - It is instantiated once inside the FSM datapath.
- Flag computation is a function in `cb_shift_pkg`, shared with the tv80 test benches.

## Test plan
- SRL, register mode, `reg_in`=7C, `flags_in`=00, count 1 → `result`=3E, `flags_out`=28, `done` in cycle 2.
- SRL, memory mode, addr 4FF2 holding AA, zero-wait ack → memory 4FF2=55, `flags_out`=04, `done` in cycle 4, one read then one write.
- RL, `reg_in`=80, `flags_in`=01 → `result`=01, `flags_out`=01.
- SRA, `reg_in`=81, count 3 → `result`=F0, `flags_out`=A4, `done` in cycle 4.
- DW=16: SLA on 8000 → `result`=0000, `flags_out`=45.
- Reset asserted in RD while `mem_ack`=0 → next cycle `mem_req`=0, `busy`=0; no write occurs. `start` during SHIFT is ignored.
